// File: rtl/rle_pkg.sv
// Shared constants for the run-length record/playback path: widths, word
// layout and FSM state codes.
package rle_pkg;

  localparam int ADDR_W   = 11;
  localparam int SAMPLE_W = 8;
  localparam int CNT_W    = 4;
  localparam int MAX_RUN  = 15;

  // Memory word layout: {sample, count} with the count in the low nibble.
  localparam int CNT_LSB    = 0;
  localparam int SAMPLE_LSB = CNT_W;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_RUN   = 3'd1;
  localparam state_t ST_FLUSH = 3'd2;
  localparam state_t ST_TERM  = 3'd3;
  localparam state_t ST_FULL  = 3'd4;

endpackage

// File: rtl/rle_run_tracker.sv
// Holds the current run (sample + count), decides when an accepted sample
// ends the run, and presents the packed memory word for that run.
module rle_run_tracker #(
  parameter int SAMPLE_W = rle_pkg::SAMPLE_W,
  parameter int CNT_W    = rle_pkg::CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      accept,
  input  logic                      clear,
  input  logic [SAMPLE_W-1:0]       sample,
  output logic                      run_end,
  output logic                      pending,
  output logic [SAMPLE_W+CNT_W-1:0] word
);
  import rle_pkg::*;

  localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(MAX_RUN);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [SAMPLE_W-1:0] held;
  logic [CNT_W-1:0]    count;

  assign pending = (count != '0);
  // A run closes on a new value or when the count field cannot grow further.
  assign run_end = accept && pending && ((sample != held) || (count == MAX_COUNT));

  always_comb begin
    word = '0;
    word[CNT_LSB +: CNT_W]       = count;
    word[SAMPLE_LSB +: SAMPLE_W] = held;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held  <= '0;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (accept) begin
      if (!pending || run_end) begin
        held  <= sample;
        count <= ONE;
      end else begin
        count <= count + ONE;
      end
    end
  end

endmodule

// File: rtl/rle_record_unit.sv
// Run-length encoding recorder writing {sample,count} words to a linear memory.
// Optional feature: define RLE_TERMINATOR_EN to append a 12'h000 word per session.
module rle_record_unit #(
  parameter int ADDR_W   = rle_pkg::ADDR_W,
  parameter int SAMPLE_W = rle_pkg::SAMPLE_W,
  parameter int CNT_W    = rle_pkg::CNT_W
) (
  input  logic                      RCLK,
  input  logic                      RCrst,
  input  logic                      WriteEn,
  input  logic                      SampleValid,
  input  logic [SAMPLE_W-1:0]       SampleIn,
  output logic [SAMPLE_W+CNT_W-1:0] SignalToMem,
  output logic                      MemWE,
  output logic [ADDR_W-1:0]         Address,
  output logic                      Full,
  output logic                      Done
);
  import rle_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t                    state;
  logic                      last_write;
  logic                      accept;
  logic                      clear;
  logic                      run_end;
  logic                      pending;
  logic [SAMPLE_W+CNT_W-1:0] word;

  // The write currently on the bus targets the final word; nothing may follow it.
  assign last_write = MemWE && (Address == LAST_ADDR);
  assign accept     = (state == ST_RUN) && WriteEn && SampleValid && !Full && !last_write;
  assign clear      = (state == ST_FLUSH) && !MemWE && pending;

  rle_run_tracker #(
    .SAMPLE_W (SAMPLE_W),
    .CNT_W    (CNT_W)
  ) u_tracker (
    .clk     (RCLK),
    .rst     (RCrst),
    .accept  (accept),
    .clear   (clear),
    .sample  (SampleIn),
    .run_end (run_end),
    .pending (pending),
    .word    (word)
  );

  // FLUSH and TERM wait for their own write to retire before finishing, so
  // Done only fires once the address has moved past the last word and never
  // when that word filled the memory.
  always_ff @(posedge RCLK) begin
    if (RCrst) begin
      state       <= ST_IDLE;
      Address     <= '0;
      SignalToMem <= '0;
      MemWE       <= 1'b0;
      Full        <= 1'b0;
      Done        <= 1'b0;
    end else begin
      MemWE <= 1'b0;
      Done  <= 1'b0;
      if (MemWE && !last_write) begin
        Address <= Address + 1'b1;
      end
      if (last_write) begin
        Full  <= 1'b1;
        state <= ST_FULL;
      end else begin
        case (state)
          ST_IDLE: begin
            if (WriteEn) begin
              state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (!WriteEn) begin
              state <= ST_FLUSH;
            end else if (run_end) begin
              SignalToMem <= word;
              MemWE       <= 1'b1;
            end
          end
          ST_FLUSH: begin
            if (!MemWE) begin
              if (pending) begin
                SignalToMem <= word;
                MemWE       <= 1'b1;
              end else begin
`ifdef RLE_TERMINATOR_EN
                state <= ST_TERM;
`else
                state <= ST_IDLE;
                Done  <= 1'b1;
`endif
              end
            end
          end
`ifdef RLE_TERMINATOR_EN
          ST_TERM: begin
            if (MemWE) begin
              state <= ST_IDLE;
              Done  <= 1'b1;
            end else begin
              SignalToMem <= '0;
              MemWE       <= 1'b1;
            end
          end
`endif
          ST_FULL: begin
            state <= ST_FULL;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rle_record_unit.sv
// Directed self-checking bench for rle_record_unit; each scenario task checks
// its own expectations, and a passive monitor logs memory writes and Done pulses.
module tb_rle_record_unit;

`ifdef RLE_TERMINATOR_EN
  localparam int TERM = 1;
`else
  localparam int TERM = 0;
`endif

  logic        RCLK = 1'b0;
  logic        RCrst;
  logic        WriteEn;
  logic        SampleValid;
  logic [7:0]  SampleIn;
  logic [11:0] SignalToMem;
  logic        MemWE;
  logic [10:0] Address;
  logic        Full;
  logic        Done;

  int compared   = 0;
  int mismatched = 0;

  logic [11:0] wr_data[$];
  logic [10:0] wr_addr[$];
  int          done_count = 0;

  rle_record_unit dut (
    .RCLK        (RCLK),
    .RCrst       (RCrst),
    .WriteEn     (WriteEn),
    .SampleValid (SampleValid),
    .SampleIn    (SampleIn),
    .SignalToMem (SignalToMem),
    .MemWE       (MemWE),
    .Address     (Address),
    .Full        (Full),
    .Done        (Done)
  );

  always #5 RCLK = ~RCLK;

  always @(negedge RCLK) begin
    if (!RCrst) begin
      if (MemWE) begin
        wr_data.push_back(SignalToMem);
        wr_addr.push_back(Address);
      end
      if (Done) done_count++;
    end
  end

  function automatic logic [11:0] data_at(int i);
    if (i < wr_data.size()) return wr_data[i];
    return 'x;
  endfunction

  function automatic logic [10:0] addr_at(int i);
    if (i < wr_addr.size()) return wr_addr[i];
    return 'x;
  endfunction

  task automatic tick();
    @(posedge RCLK);
    #1;
  endtask

  task automatic clear_log();
    wr_data.delete();
    wr_addr.delete();
    done_count = 0;
  endtask

  task automatic do_reset();
    RCrst = 1'b1; WriteEn = 1'b0; SampleValid = 1'b0; SampleIn = 8'h00;
    tick(); tick();
    RCrst = 1'b0;
    clear_log();
  endtask

  task automatic start_session();
    WriteEn = 1'b1; SampleValid = 1'b0;
    tick();
  endtask

  task automatic drive_sample(input logic [7:0] v);
    WriteEn = 1'b1; SampleValid = 1'b1; SampleIn = v;
    tick();
    SampleValid = 1'b0;
  endtask

  task automatic end_session_wait();
    WriteEn = 1'b0; SampleValid = 1'b0;
    for (int i = 0; i < 30 && done_count == 0; i++) tick();
    tick(); tick();
  endtask

  task automatic prefill(input int n);
    do_reset();
    start_session();
    for (int i = 0; i < n; i++) drive_sample(i[0] ? 8'h02 : 8'h01);
    end_session_wait();
  endtask

  task automatic test_reset();
    RCrst = 1'b1; WriteEn = 1'b1; SampleValid = 1'b1; SampleIn = 8'h5A;
    tick(); tick();
    compared++; if (Address !== 11'd0) begin mismatched++; $display("[TB] FAIL reset_addr: got %h, expected %h", Address, 11'd0); end
    compared++; if (SignalToMem !== 12'h000) begin mismatched++; $display("[TB] FAIL reset_data: got %h, expected %h", SignalToMem, 12'h000); end
    compared++; if (MemWE !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_we: got %b, expected 0", MemWE); end
    compared++; if (Full !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_full: got %b, expected 0", Full); end
    compared++; if (Done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b, expected 0", Done); end
    RCrst = 1'b0; WriteEn = 1'b0; SampleValid = 1'b0;
    clear_log();
  endtask

  task automatic test_basic();
    do_reset();
    start_session();
    drive_sample(8'h05); drive_sample(8'h05); drive_sample(8'h05);
    drive_sample(8'h09);
    compared++; if (MemWE !== 1'b1 || SignalToMem !== 12'h053 || Address !== 11'd0) begin mismatched++; $display("[TB] FAIL basic_latency: got we=%b data=%h addr=%h, expected we=1 data=053 addr=000", MemWE, SignalToMem, Address); end
    end_session_wait();
    compared++; if (wr_data.size() !== 2 + TERM) begin mismatched++; $display("[TB] FAIL basic_count: got %0d, expected %0d", wr_data.size(), 2 + TERM); end
    compared++; if (data_at(0) !== 12'h053 || addr_at(0) !== 11'd0) begin mismatched++; $display("[TB] FAIL basic_w0: got %h@%h, expected 053@000", data_at(0), addr_at(0)); end
    compared++; if (data_at(1) !== 12'h091 || addr_at(1) !== 11'd1) begin mismatched++; $display("[TB] FAIL basic_w1: got %h@%h, expected 091@001", data_at(1), addr_at(1)); end
`ifdef RLE_TERMINATOR_EN
    compared++; if (data_at(2) !== 12'h000 || addr_at(2) !== 11'd2) begin mismatched++; $display("[TB] FAIL basic_term: got %h@%h, expected 000@002", data_at(2), addr_at(2)); end
`endif
    compared++; if (done_count !== 1) begin mismatched++; $display("[TB] FAIL basic_done: got %0d cycles, expected 1", done_count); end
    compared++; if (Address !== 11'(2 + TERM)) begin mismatched++; $display("[TB] FAIL basic_next_addr: got %h, expected %h", Address, 11'(2 + TERM)); end
  endtask

  task automatic test_saturation();
    do_reset();
    start_session();
    for (int i = 0; i < 20; i++) drive_sample(8'hAA);
    end_session_wait();
    compared++; if (wr_data.size() !== 2 + TERM) begin mismatched++; $display("[TB] FAIL sat_count: got %0d, expected %0d", wr_data.size(), 2 + TERM); end
    compared++; if (data_at(0) !== 12'hAAF || addr_at(0) !== 11'd0) begin mismatched++; $display("[TB] FAIL sat_w0: got %h@%h, expected AAF@000", data_at(0), addr_at(0)); end
    compared++; if (data_at(1) !== 12'hAA5 || addr_at(1) !== 11'd1) begin mismatched++; $display("[TB] FAIL sat_w1: got %h@%h, expected AA5@001", data_at(1), addr_at(1)); end
    compared++; if (done_count !== 1) begin mismatched++; $display("[TB] FAIL sat_done: got %0d, expected 1", done_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start_session();
    drive_sample(8'h01); drive_sample(8'h02); drive_sample(8'h03);
    compared++; if (MemWE !== 1'b1 || SignalToMem !== 12'h021 || Address !== 11'd1) begin mismatched++; $display("[TB] FAIL b2b_second: got we=%b data=%h addr=%h, expected we=1 data=021 addr=001", MemWE, SignalToMem, Address); end
    end_session_wait();
    compared++; if (data_at(0) !== 12'h011 || addr_at(0) !== 11'd0) begin mismatched++; $display("[TB] FAIL b2b_w0: got %h@%h, expected 011@000", data_at(0), addr_at(0)); end
    compared++; if (data_at(2) !== 12'h031 || addr_at(2) !== 11'd2) begin mismatched++; $display("[TB] FAIL b2b_w2: got %h@%h, expected 031@002", data_at(2), addr_at(2)); end
    compared++; if (wr_data.size() !== 3 + TERM) begin mismatched++; $display("[TB] FAIL b2b_count: got %0d, expected %0d", wr_data.size(), 3 + TERM); end
  endtask

  task automatic test_ignore();
    do_reset();
    WriteEn = 1'b0; SampleValid = 1'b1; SampleIn = 8'h55;
    repeat (4) tick();
    SampleValid = 1'b0;
    compared++; if (wr_data.size() !== 0 || Address !== 11'd0 || done_count !== 0) begin mismatched++; $display("[TB] FAIL idle_ignore: got writes=%0d addr=%h done=%0d, expected 0/000/0", wr_data.size(), Address, done_count); end
    start_session();
    drive_sample(8'h12); drive_sample(8'h12);
    WriteEn = 1'b0; SampleValid = 1'b1; SampleIn = 8'h34;
    tick();
    SampleValid = 1'b0;
    end_session_wait();
    compared++; if (wr_data.size() !== 1 + TERM) begin mismatched++; $display("[TB] FAIL fall_count: got %0d, expected %0d", wr_data.size(), 1 + TERM); end
    compared++; if (data_at(0) !== 12'h122 || addr_at(0) !== 11'd0) begin mismatched++; $display("[TB] FAIL fall_w0: got %h@%h, expected 122@000", data_at(0), addr_at(0)); end
    compared++; if (done_count !== 1) begin mismatched++; $display("[TB] FAIL fall_done: got %0d, expected 1", done_count); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    start_session();
    drive_sample(8'h21);
    end_session_wait();
    clear_log();
    start_session();
    for (int i = 0; i < 7; i++) drive_sample(8'h33);
    RCrst = 1'b1; WriteEn = 1'b1; SampleValid = 1'b1; SampleIn = 8'h44;
    tick();
    compared++; if (MemWE !== 1'b0 || Address !== 11'd0 || SignalToMem !== 12'h000 || Full !== 1'b0 || Done !== 1'b0) begin mismatched++; $display("[TB] FAIL midrun_reset: got we=%b addr=%h data=%h full=%b done=%b, expected all 0", MemWE, Address, SignalToMem, Full, Done); end
    RCrst = 1'b0; SampleValid = 1'b0;
    start_session();
    drive_sample(8'h44); drive_sample(8'h44);
    end_session_wait();
    compared++; if (data_at(0) !== 12'h442 || addr_at(0) !== 11'd0 || wr_data.size() !== 1 + TERM) begin mismatched++; $display("[TB] FAIL midrun_fresh: got %h@%h n=%0d, expected 442@000 n=%0d", data_at(0), addr_at(0), wr_data.size(), 1 + TERM); end
  endtask

  task automatic test_full();
    prefill(2046 - TERM);
    compared++; if (Address !== 11'd2046) begin mismatched++; $display("[TB] FAIL full_preset: got %h, expected %h", Address, 11'd2046); end
    clear_log();
    start_session();
    drive_sample(8'hA0); drive_sample(8'hB0); drive_sample(8'hC0); drive_sample(8'hD0);
    drive_sample(8'hE0); drive_sample(8'hF0);
    WriteEn = 1'b0;
    repeat (10) tick();
    WriteEn = 1'b1; SampleValid = 1'b1; SampleIn = 8'h11;
    repeat (4) tick();
    WriteEn = 1'b0; SampleValid = 1'b0;
    repeat (4) tick();
    compared++; if (wr_data.size() !== 2) begin mismatched++; $display("[TB] FAIL full_count: got %0d, expected 2", wr_data.size()); end
    compared++; if (data_at(0) !== 12'hA01 || addr_at(0) !== 11'd2046) begin mismatched++; $display("[TB] FAIL full_w0: got %h@%h, expected A01@7FE", data_at(0), addr_at(0)); end
    compared++; if (data_at(1) !== 12'hB01 || addr_at(1) !== 11'd2047) begin mismatched++; $display("[TB] FAIL full_w1: got %h@%h, expected B01@7FF", data_at(1), addr_at(1)); end
    compared++; if (Full !== 1'b1 || Address !== 11'd2047) begin mismatched++; $display("[TB] FAIL full_flag: got full=%b addr=%h, expected 1/7FF", Full, Address); end
    compared++; if (done_count !== 0) begin mismatched++; $display("[TB] FAIL full_nodone: got %0d, expected 0", done_count); end
  endtask

  task automatic test_full_flush();
    prefill(2047 - TERM);
    compared++; if (Full !== 1'b0 || Address !== 11'd2047) begin mismatched++; $display("[TB] FAIL ffl_preset: got full=%b addr=%h, expected 0/7FF", Full, Address); end
    clear_log();
    start_session();
    drive_sample(8'h77);
    WriteEn = 1'b0;
    repeat (12) tick();
    compared++; if (wr_data.size() !== 1 || data_at(0) !== 12'h771 || addr_at(0) !== 11'd2047) begin mismatched++; $display("[TB] FAIL ffl_write: got %h@%h n=%0d, expected 771@7FF n=1", data_at(0), addr_at(0), wr_data.size()); end
    compared++; if (Full !== 1'b1 || done_count !== 0) begin mismatched++; $display("[TB] FAIL ffl_state: got full=%b done=%0d, expected 1/0", Full, done_count); end
  endtask

  initial begin
    RCrst = 1'b1; WriteEn = 1'b0; SampleValid = 1'b0; SampleIn = 8'h00;
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_ignore();
    test_reset_mid_run();
    test_full();
    test_full_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rle_record_unit.md
RLE_RECORD_UNIT -- requirements
Module: rle_record_unit

Interface
REQ-001 SHALL have the following parameters (name, default, meaning):
  ADDR_W, 11, memory word address width (2048 words).
  SAMPLE_W, 8, sample width.
  CNT_W, 4, run-count width (maximum run 15).
REQ-002 SHALL have the following ports (name, direction, width, meaning):
  RCLK, input, 1, the single clock; all logic on its rising edge.
  RCrst, input, 1, reset; synchronous, active-high.
  WriteEn, input, 1, record session active.
  SampleValid, input, 1, SampleIn carries a new sample this cycle.
  SampleIn, input, 8, audio sample.
  SignalToMem, output, 12, memory write word: {sample[11:4], count[3:0]}.
  MemWE, output, 1, one-cycle memory write strobe.
  Address, output, 11, memory write address.
  Full, output, 1, memory exhausted; sticky.
  Done, output, 1, one-cycle pulse when a session has been fully flushed.

Function
REQ-003 SHALL encode accepted samples as run-length words, one word per run of identical consecutive samples; count = number of samples in the run, range 1..15.
REQ-004 SHALL accept a sample only when WriteEn=1, SampleValid=1, state=RUN and Full=0; all other samples SHALL be ignored.
REQ-005 SHALL implement states IDLE, RUN, FLUSH, TERM and FULL:
  IDLE->RUN on WriteEn=1.
  RUN->FLUSH on WriteEn=0.
  FLUSH->TERM when RLE_TERMINATOR_EN is defined, otherwise FLUSH->IDLE.
  TERM->IDLE.
  Any state->FULL after the write to the last address.
REQ-006 On the first accepted sample of a run (count=0), SHALL load the sample and set count=1 with no write.
REQ-007 On an accepted sample equal to the held sample with count<15, SHALL increment count with no write.
REQ-008 On an accepted sample that differs, or any accepted sample while count=15, SHALL write {held,count} and then start a new run with the new sample and count=1.
REQ-009 Write latency SHALL be one cycle: MemWE=1 in the cycle after the triggering edge, with SignalToMem and Address valid in that same cycle.
REQ-010 Address SHALL increment by 1 on the edge that ends each MemWE cycle.
REQ-011 MemWE SHALL never be high for two consecutive cycles driven by the same word.
REQ-012 In FLUSH, SHALL write the pending run if count>0, then clear count; with count=0, SHALL write nothing.
REQ-013 Done SHALL pulse for exactly one cycle on entering IDLE from FLUSH or TERM.
REQ-014 Address SHALL be retained across sessions, so a new session appends after the previous one.
REQ-015 A write at Address=2047 SHALL set Full=1 and enter FULL; Address SHALL NOT wrap.
REQ-016 In FULL, MemWE=0 and all inputs SHALL be ignored until reset.
REQ-017 If Full is reached during FLUSH or TERM, Done SHALL NOT pulse.
REQ-018 If WriteEn falls in the same cycle as a run-terminating sample, that sample SHALL be ignored and only the held run SHALL be flushed.
REQ-019 A count-0 word SHALL never be emitted except as the terminator.

Reset
REQ-020 While RCrst=1, SHALL set state=IDLE, Address=0, SignalToMem=0, MemWE=0, Full=0, Done=0, count=0 and held sample=0.
REQ-021 Reset SHALL take priority over all other events; a run in progress is discarded without a write.

Configuration
REQ-022 With RLE_TERMINATOR_EN defined, TERM SHALL write word 12'h000 (sample 0, count 0) at the current Address after the flush, consuming one address, subject to Full.
REQ-023 Without RLE_TERMINATOR_EN, TERM SHALL be absent and no terminator word SHALL be written.

Structure
REQ-024 Package rle_pkg SHALL hold ADDR_W, SAMPLE_W, CNT_W, MAX_RUN=15, the word-packing field positions and the state enumeration; the playback unit SHALL share the same package.
REQ-025 Sub-module rle_run_tracker SHALL hold the sample/count registers and the compare/saturate logic, and SHALL output the run-end and word signals.

Verification
REQ-026 Samples 5,5,5,9 with WriteEn held, then WriteEn=0 -> words 12'h053 @0 and 12'h091 @1, then Done; with RLE_TERMINATOR_EN, additionally 12'h000 @2.
REQ-027 Twenty consecutive samples of 0xAA -> words 12'hAAF @0 and 12'hAA5 @1 after flush.
REQ-028 Address preset to 2046 via prior traffic, then four distinct samples -> writes at 2046 and 2047, Full=1, no further MemWE, no Done.
REQ-029 RCrst asserted mid-run with count=7 -> no write; next cycle Address=0 and all outputs 0.
REQ-030 SampleValid=1 with WriteEn=0 in IDLE -> no state change and no MemWE; WriteEn falling together with a differing sample -> only the held run is written.
